// File: rtl/qenc_gen_pkg.sv
//==============================================================================
// qenc_gen_pkg : shared types and constants for the quadrature-encoder generator
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package qenc_gen_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] c_addr_period = 2'd0;
    localparam logic [1:0] c_addr_launch = 2'd1;
    localparam logic [1:0] c_addr_sw     = 2'd2;
    localparam logic [1:0] c_addr_abort  = 2'd3;

    localparam int c_period_rst = 1000;

    // Gray-coded {A,B}; increasing phase makes A lead B (CW).
    function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
        logic [1:0] ab;
        case (ph)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qenc_tick_gen.sv
//==============================================================================
// qenc_tick_gen : step-interval counter, one-cycle tick at terminal count
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module qenc_tick_gen #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] r_lim;
    logic [PW-1:0] w_peff;

    assign w_peff = (period < PW'(2)) ? PW'(2) : period;
    assign tick   = enable && (r_cnt == (r_lim - PW'(1)));

    // The limit is only reloaded at a wrap or while idle, so a period
    // change never shortens or stretches the interval in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_lim <= PW'(2);
        end else if (!enable || tick) begin
            r_cnt <= '0;
            r_lim <= w_peff;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/chu_qenc_gen.sv
//==============================================================================
// chu_qenc_gen : MMIO slot emitting quadrature-encoder A/B steps and a switch level
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module chu_qenc_gen
    import qenc_gen_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        enc_a,
    output logic        enc_b,
    output logic        enc_sw
);

    state_t        r_state;
    logic [PW-1:0] r_period;
    logic [PW-1:0] r_remaining;
    logic          r_dir;
    logic [1:0]    r_phase;
    logic [31:0]   r_pos;
    logic          r_enc_a;
    logic          r_enc_b;
    logic          r_sw;

    logic          w_wr;
    logic          w_period_wr;
    logic          w_launch;
    logic          w_sw_wr;
    logic          w_abort;
    logic          w_busy;
    logic          w_tick;
    logic          w_tick_en;
    logic [1:0]    w_phase_nxt;
    logic [31:0]   w_rem32;
    logic          w_unused_ok;

    assign w_wr        = cs & write;
    assign w_busy      = (r_state == S_RUN);
    assign w_period_wr = w_wr && (addr[1:0] == c_addr_period);
    assign w_sw_wr     = w_wr && (addr[1:0] == c_addr_sw);
    assign w_launch    = w_wr && (addr[1:0] == c_addr_launch) && !w_busy
                         && (wr_data[PW-1:0] != '0);
    assign w_abort     = w_wr && (addr[1:0] == c_addr_abort) && w_busy;
    assign w_phase_nxt = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
    assign w_rem32     = 32'(r_remaining);

    // Abort also clears the counter on its own edge and blocks a coincident step.
    assign w_tick_en   = w_busy && !w_abort;

    assign w_unused_ok = ^{read, addr[4:2], wr_data};

    qenc_tick_gen #(
        .PW(PW)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .enable(w_tick_en),
        .period(r_period),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_period    <= PW'(c_period_rst);
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_phase     <= 2'd0;
            r_pos       <= 32'd0;
            r_enc_a     <= 1'b0;
            r_enc_b     <= 1'b0;
            r_sw        <= 1'b0;
        end else begin
            if (w_period_wr) r_period <= wr_data[PW-1:0];
            if (w_sw_wr)     r_sw     <= wr_data[0];
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_remaining <= wr_data[PW-1:0];
                        r_dir       <= wr_data[16];
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_remaining <= '0;
                        r_state     <= S_IDLE;
                    end else if (w_tick) begin
                        // A/B follow the next phase directly so the edge lands on the step clock.
                        r_phase            <= w_phase_nxt;
                        {r_enc_a, r_enc_b} <= phase_to_ab(w_phase_nxt);
                        r_remaining        <= r_remaining - PW'(1);
                        r_pos              <= r_dir ? (r_pos - 32'd1) : (r_pos + 32'd1);
                        if (r_remaining == PW'(1)) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr[1:0])
            c_addr_period: rd_data = {w_rem32[15:0], 12'b0, r_phase, r_sw, w_busy};
            c_addr_launch: rd_data = 32'(r_period);
            c_addr_sw:     rd_data = r_pos;
            default:       rd_data = 32'd0;
        endcase
    end

    assign enc_a  = r_enc_a;
    assign enc_b  = r_enc_b;
    assign enc_sw = r_sw;

endmodule

`default_nettype wire

// File: doc/chu_qenc_gen.md
CHU_QENC_GEN -- requirements
Module: chu_qenc_gen

Interface
REQ-001 SHALL have parameter PW, default 16, meaning width of the period register and of the step-count field.
REQ-002 SHALL have port clk, input, 1 bit: the single clock domain.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port cs, input, 1 bit: slot select.
REQ-005 SHALL have port read, input, 1 bit: bus read strobe; reads have no side effects.
REQ-006 SHALL have port write, input, 1 bit: bus write strobe; a write acts only when cs=1 and write=1.
REQ-007 SHALL have port addr, input, 5 bits: register offset; only addr[1:0] is decoded.
REQ-008 SHALL have port wr_data, input, 32 bits: write data.
REQ-009 SHALL have port rd_data, output, 32 bits: combinational read mux.
REQ-010 SHALL have port enc_a, output, 1 bit: quadrature channel A.
REQ-011 SHALL have port enc_b, output, 1 bit: quadrature channel B.
REQ-012 SHALL have port enc_sw, output, 1 bit: emulated push-switch level.

Function
REQ-013 SHALL act as an MMIO slot core that generates quadrature-encoder waveforms; it is the stimulus counterpart of the encoder decoder slot.
REQ-014 SHALL define register writes as:
- addr 0: PERIOD <= wr_data[PW-1:0]
- addr 1: launch, with count = wr_data[PW-1:0] and dir = wr_data[16] (0 = CW, 1 = CCW)
- addr 2: enc_sw <= wr_data[0]
- addr 3: abort, with data ignored.
REQ-015 SHALL define register reads as:
- addr 0: status = {remaining[15:0], 12'b0, phase[1:0], enc_sw, busy}
- addr 1: PERIOD, zero-extended
- addr 2: 32-bit signed position
- addr 3: 0.
REQ-016 SHALL use an FSM with two states:
- IDLE -> RUN on a launch write with count != 0
- RUN -> IDLE on the step that brings remaining to 0, or on abort.
REQ-017 SHALL assert busy exactly while in RUN.
REQ-018 SHALL treat the effective period as max(PERIOD, 2) clocks per quadrature step.
REQ-019 SHALL, in RUN, run a tick counter from 0 to effective period - 1; at the terminal count it issues one step, and the counter wraps to 0.
REQ-020 SHALL, on each step:
- advance phase by +1 (CW) or -1 (CCW), modulo 4
- decrement remaining by 1
- add +1 (CW) or -1 (CCW) to position.
REQ-021 SHALL register the outputs {enc_a, enc_b} from phase as 0->00, 1->10, 2->11, 3->01, so that A leads B for CW.
REQ-022 SHALL place the first output transition exactly effective-period cycles after the launch write cycle; each later transition follows at the same spacing.
REQ-023 SHALL ignore a launch write with count = 0 (remain in IDLE).
REQ-024 SHALL ignore a launch write received while busy.
REQ-025 SHALL, on abort, enter IDLE on the next clock, clear remaining and the tick counter, and hold phase and the outputs; abort in IDLE is a no-op.
REQ-026 SHALL make a PERIOD write during RUN take effect from the next tick-counter wrap.
REQ-027 SHALL make position wrap modulo 2^32 in two's complement.
REQ-028 SHALL make an enc_sw write take effect on the next clock, independent of FSM state.

Reset
REQ-029 SHALL, while reset=0 at a rising clk, set:
- state IDLE, busy 0
- PERIOD = 1000
- remaining, tick counter, phase, position = 0
- enc_a, enc_b, enc_sw = 0.
REQ-030 SHALL, on reset in the middle of RUN, abandon the step sequence and apply REQ-029 values on that clock.

Structure
REQ-031 SHALL place in shared package qenc_gen_pkg: the state enum, register offset constants, the phase-to-AB lookup, and the reset PERIOD constant.
REQ-032 SHALL implement the tick counter and terminal-count pulse as sub-module qenc_tick_gen (inputs clk, reset, enable, period; output tick).

Verification
REQ-033 SHALL verify basic CW stepping: PERIOD=4, launch count=5 CW -> AB goes 10,11,01,00,10 at cycles +4,+8,+12,+16,+20; busy drops after the 5th step; position = 5; phase = 1.
REQ-034 SHALL verify CCW stepping and wrap: from position 0, PERIOD=2, launch count=3 CCW -> AB goes 01,11,10 every 2 cycles; position reads 0xFFFFFFFD.
REQ-035 SHALL verify abort: launch count=100 with PERIOD=10, abort after 35 cycles -> exactly 3 steps taken; busy=0; remaining=0; AB held at 01.
REQ-036 SHALL verify ignored writes: launch count=0 -> busy stays 0; a second launch while busy -> remaining unchanged; PERIOD=0 or 1 -> steps spaced 2 cycles.
REQ-037 SHALL verify mid-run PERIOD change: PERIOD changed from 8 to 3 during RUN -> the current interval completes at 8, later steps are spaced 3; enc_sw write of 1 -> enc_sw=1 next cycle.
REQ-038 SHALL verify reset mid-RUN: reset low for 1 cycle -> all outputs 0, PERIOD reads 1000, status reads 0.
